// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - word-to-bit serializer with holding register and shift register
// Optional even-parity bit after each word: define SERIAL_FEEDER_PARITY_EN.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);
`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             last_bit;
    logic             accept;
    logic             load;
    logic             sr_bit;
    logic             tx_bit;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             par_q;
`endif

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign accept   = data_valid && data_ready;
    // hold drains either from IDLE or straight into the shifter on the last bit (gapless)
    assign load     = hold_full_q && ((state_q == IDLE) || last_bit);
    assign cnt_d    = cnt_q + CW'(1);
    assign sr_d     = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    assign sr_bit   = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

`ifdef SERIAL_FEEDER_PARITY_EN
    assign tx_bit = (cnt_q == CW'(WIDTH)) ? par_q : sr_bit;
`else
    assign tx_bit = sr_bit;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            // accept and load are exclusive: accept needs an empty hold, load a full one
            if (accept) begin
                hold_q      <= data_in;
                hold_full_q <= 1'b1;
            end
            if (load) begin
                sr_q        <= hold_q;
                hold_full_q <= 1'b0;
                cnt_q       <= '0;
                state_q     <= SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
                par_q       <= ^hold_q;
`endif
            end else if (state_q == SHIFT) begin
                if (last_bit) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_d;
                    sr_q  <= sr_d;
                end
            end
        end
    end

    assign data_ready   = !hold_full_q && !reset;
    assign bit_valid    = (state_q == SHIFT);
    assign word_done    = last_bit;
    assign sequence_out = bit_valid && tx_bit;
    assign busy         = bit_valid || hold_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - scoreboard bench for serial_bit_feeder
// Build with SERIAL_FEEDER_PARITY_EN to exercise the parity frame.
module tb_serial_bit_feeder;
`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       sequence_out;
    logic       bit_valid;
    logic       word_done;
    logic       busy;

    logic [7:0] lsb_data;
    logic       lsb_valid;
    logic       lsb_ready;
    logic       lsb_seq;
    logic       lsb_bv;
    logic       lsb_wd;
    logic       lsb_busy;

    int   total;
    int   bad;
    int   cyc;
    int   bits_seen;
    int   run;
    int   max_run;
    exp_t q[$];
    int   pop_cyc[$];
    int   wd_cyc[$];

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .sequence_out(sequence_out), .bit_valid(bit_valid),
        .word_done(word_done), .busy(busy)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .data_in(lsb_data), .data_valid(lsb_valid),
        .data_ready(lsb_ready), .sequence_out(lsb_seq), .bit_valid(lsb_bv),
        .word_done(lsb_wd), .busy(lsb_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: the word's bits in send order, then even parity when enabled.
    function automatic void push_word(input logic [7:0] w, input bit msb_first, inout exp_t qq[$]);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = msb_first ? w[7 - i] : w[i];
            e.last = (i == FRAME - 1);
            qq.push_back(e);
        end
        if (FRAME == 9) begin
            e.b    = ^w;
            e.last = 1'b1;
            qq.push_back(e);
        end
    endfunction

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [7:0] w, output int waits, output int qsz, output int acc);
        waits = 0;
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && waits < 200) begin
            @(posedge clock); #2;
            waits++;
        end
        qsz = q.size();
        if (!data_ready) begin
            chk("send_timeout", 0, 1);
            data_valid = 1'b0;
            acc = -1;
        end else begin
            push_word(w, 1'b1, q);
            @(posedge clock); #2;
            acc = cyc;
            data_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bit_valid) && n < 300) begin
            @(posedge clock); #2;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
        repeat (2) begin @(posedge clock); #2; end
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        wd_cyc.delete();
        max_run = 0;
    endtask

    // Monitor: every presented bit is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (!reset) begin
            if (bit_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sequence_out", int'(sequence_out), int'(e.b));
                    chk("word_done", int'(word_done), int'(e.last));
                end
                chk("busy_while_valid", int'(busy), 1);
                pop_cyc.push_back(cyc);
                if (word_done) wd_cyc.push_back(cyc);
                bits_seen++;
                run++;
            end else begin
                chk("idle_sequence_out", int'(sequence_out), 0);
                chk("idle_word_done", int'(word_done), 0);
                if (run > max_run) max_run = run;
                run = 0;
            end
        end
    end

    initial begin
        int   waits, qsz, acc, base, wd_before, n;
        logic lbits[$];
        logic lwd[$];
        exp_t lexp[$];

        total = 0; bad = 0; cyc = 0; bits_seen = 0; run = 0; max_run = 0;
        reset = 1'b1; data_in = '0; data_valid = 1'b0; lsb_data = '0; lsb_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(data_ready), 0);
        chk("rst_word_done", int'(word_done), 0);
        chk("rst_seq", int'(sequence_out), 0);
        reset = 1'b0;
        #0;
        chk("ready_after_rst", int'(data_ready), 1);
        @(posedge clock); #2;

        // single word: latency and word_done position
        clear_logs();
        send(8'hB5, waits, qsz, acc);
        drain();
        chk("t1_bits", pop_cyc.size(), FRAME);
        if (pop_cyc.size() > 0) chk("t1_first_latency", pop_cyc[0] - acc, 1);
        chk("t1_wd_count", wd_cyc.size(), 1);
        if (wd_cyc.size() > 0) chk("t1_last_latency", wd_cyc[0] - acc, FRAME);

        // back-to-back words stream gaplessly
        clear_logs();
        send(8'hA5, waits, qsz, acc);
        send(8'h3C, waits, qsz, acc);
        drain();
        chk("t2_run", max_run, 2 * FRAME);
        chk("t2_wd_count", wd_cyc.size(), 2);
        if (wd_cyc.size() == 2) chk("t2_wd_spacing", wd_cyc[1] - wd_cyc[0], FRAME);

        // third word waits for the reload edge
        clear_logs();
        send(8'hA5, waits, qsz, acc);
        send(8'h3C, waits, qsz, acc);
        send(8'hFF, waits, qsz, acc);
        chk("t3_ready_low_cycles", waits, FRAME - 1);
        chk("t3_queue_at_accept", qsz, FRAME);
        drain();
        chk("t3_run", max_run, 3 * FRAME);

        // reset mid-frame discards the frame and the held word
        send(8'hB5, waits, qsz, acc);
        base = bits_seen;
        send(8'h77, waits, qsz, acc);
        n = 0;
        while (bits_seen < base + 4 && n < 50) begin @(posedge clock); #2; n++; end
        chk("t4_reached_bit4", bits_seen - base, 4);
        wd_before = wd_cyc.size();
        reset = 1'b1;
        @(posedge clock); #2;
        chk("t4_ready_in_reset", int'(data_ready), 0);
        chk("t4_bit_valid", int'(bit_valid), 0);
        chk("t4_seq", int'(sequence_out), 0);
        chk("t4_busy", int'(busy), 0);
        q.delete();
        reset = 1'b0;
        repeat (20) begin @(posedge clock); #2; end
        chk("t4_no_word_done", wd_cyc.size(), wd_before);
        chk("t4_idle_busy", int'(busy), 0);

        // randomized traffic with random idle gaps
        clear_logs();
        for (int k = 0; k < 30; k++) begin
            send(8'($urandom), waits, qsz, acc);
            repeat ($urandom_range(0, 3)) begin @(posedge clock); #2; end
        end
        drain();
        chk("rand_queue_empty", q.size(), 0);

        // LSB-first instance
        push_word(8'h0D, 1'b0, lexp);
        lsb_data = 8'h0D;
        lsb_valid = 1'b1;
        n = 0;
        while (!lsb_ready && n < 20) begin @(posedge clock); #2; n++; end
        @(posedge clock); #2;
        lsb_valid = 1'b0;
        repeat (FRAME + 6) begin
            @(negedge clock);
            if (lsb_bv) begin
                lbits.push_back(lsb_seq);
                lwd.push_back(lsb_wd);
            end
        end
        chk("t5_bits", lbits.size(), FRAME);
        for (int i = 0; i < FRAME && i < lbits.size(); i++) begin
            chk($sformatf("t5_bit%0d", i), int'(lbits[i]), int'(lexp[i].b));
            chk($sformatf("t5_wd%0d", i), int'(lwd[i]), int'(lexp[i].last));
        end
        chk("t5_busy_end", int'(lsb_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
